// File: rtl/doodle_pkg.sv
// Shared types and constants for the doodle platform path.
// Used by platform_manager, its interface and the lfsr16 generator.
package doodle_pkg;

  localparam int NUM_PLATFORMS = 8;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    RUN,
    SCAN
  } plat_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback taps at bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam coord_t     H           = 10'd480;
  localparam coord_t     W           = 10'd640;
  localparam coord_t     X_MIN       = 10'd140;
  localparam coord_t     X_MAX       = 10'd499;
  localparam logic [7:0] PLAT_SIZE   = 8'd60;
  localparam coord_t     SCROLL_LINE = 10'd160;
  localparam coord_t     DY_MAX      = 10'd15;

  localparam coord_t X_HI    = X_MAX - {2'b00, PLAT_SIZE};
  localparam coord_t X_START = (W - {2'b00, PLAT_SIZE}) >> 1;
  localparam coord_t INIT_Y0 = H - 10'd40;
  localparam coord_t INIT_DY = 10'd56;

  function automatic coord_t rand_x(input logic [8:0] off);
    logic [8:0] o;
    o = off;
    if (o >= 9'd300) o = o - 9'd300;
    return X_MIN + {1'b0, o};
  endfunction

endpackage

// File: rtl/platform_manager_if.sv
// Bus between platform_manager (master) and its consumers (slave).
// Carries game inputs plus the platform arrays and scroll/score outputs.
interface platform_manager_if;
  import doodle_pkg::*;

  logic [1:0]  frame_clk_edge;
  logic [7:0]  state;
  coord_t      Doodle_Y;
  coord_t      Platform_X [0:NUM_PLATFORMS-1];
  coord_t      Platform_Y [0:NUM_PLATFORMS-1];
  logic [7:0]  platform_size;
  coord_t      scroll_dy;
  logic        scroll_valid;
  logic [15:0] score;
  logic        busy;

  modport master (
    input  frame_clk_edge, state, Doodle_Y,
    output Platform_X, Platform_Y, platform_size,
    output scroll_dy, scroll_valid, score, busy
  );

  modport slave (
    output frame_clk_edge, state, Doodle_Y,
    input  Platform_X, Platform_Y, platform_size,
    input  scroll_dy, scroll_valid, score, busy
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, synchronous reset to the seed.
// Nonzero seed keeps it out of the all-zero lock-up state.
module lfsr16
  import doodle_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  output logic [15:0] lfsr
);

  always_ff @(posedge Clk) begin
    if (Reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

endmodule

// File: rtl/platform_manager.sv
// Spawns, scrolls and recycles the eight landing platforms.
// Build option PLATFORM_DRIFT_EN: odd slots drift 1 px sideways per frame.
module platform_manager
  import doodle_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  platform_manager_if.master bus
);

  plat_state_t st_q, st_d;
  logic [2:0]  slot_q, slot_d;
  coord_t      px_q [NUM_PLATFORMS];
  coord_t      py_q [NUM_PLATFORMS];
  coord_t      dy_q;
  logic        sv_q;
  logic [15:0] score_q;
  logic [15:0] lfsr;
  logic        unused_lfsr;

  logic   frame, playing, stop, respawn;
  coord_t dy_new, y_sum, x_rand, y_spawn, y_init;

  lfsr16 u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .lfsr  (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:13];

  assign frame   = bus.frame_clk_edge == 2'b01;
  assign playing = bus.state == 8'd1;
  assign stop    = bus.state == 8'd0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      st_q   <= IDLE;
      slot_q <= '0;
    end else begin
      st_q   <= st_d;
      slot_q <= slot_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    slot_d = slot_q;
    unique case (st_q)
      IDLE: begin
        if (playing) begin
          st_d   = INIT;
          slot_d = '0;
        end
      end
      INIT, SCAN: begin
        slot_d = slot_q + 3'd1;
        if (slot_q == 3'd7) st_d = RUN;
      end
      RUN: begin
        if (stop) begin
          st_d = IDLE;
        end else if (playing && frame) begin
          st_d   = SCAN;
          slot_d = '0;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    dy_new = '0;
    if (bus.Doodle_Y < SCROLL_LINE) begin
      dy_new = SCROLL_LINE - bus.Doodle_Y;
      if (dy_new > DY_MAX) dy_new = DY_MAX;
    end
  end

  // Y stays below 496, so the 10-bit sum cannot wrap
  assign y_sum   = py_q[slot_q] + dy_q;
  assign respawn = y_sum >= H;
  assign x_rand  = rand_x(lfsr[8:0]);
  assign y_spawn = {6'd0, lfsr[12:9]};
  assign y_init  = INIT_Y0 - INIT_DY * {7'd0, slot_q};

`ifdef PLATFORM_DRIFT_EN
  logic [NUM_PLATFORMS-1:0] dir_q;
  coord_t x_cur, x_drift;
  logic   dir_flip;

  assign x_cur = px_q[slot_q];

  // dir_q bit set means moving left; bounce keeps X inside the field
  always_comb begin
    x_drift  = x_cur;
    dir_flip = 1'b0;
    if (slot_q[0]) begin
      if (dir_q[slot_q]) begin
        if (x_cur <= X_MIN) begin
          dir_flip = 1'b1;
          x_drift  = x_cur + 10'd1;
        end else begin
          x_drift = x_cur - 10'd1;
        end
      end else begin
        if (x_cur >= X_HI) begin
          dir_flip = 1'b1;
          x_drift  = x_cur - 10'd1;
        end else begin
          x_drift = x_cur + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      dir_q <= '0;
    end else if (st_q == SCAN && !respawn && dir_flip) begin
      dir_q[slot_q] <= ~dir_q[slot_q];
    end
  end
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_PLATFORMS; i++) begin
        px_q[i] <= '0;
        py_q[i] <= H;
      end
      dy_q    <= '0;
      sv_q    <= 1'b0;
      score_q <= '0;
    end else begin
      sv_q <= 1'b0;
      unique case (st_q)
        INIT: begin
          px_q[slot_q] <= (slot_q == 3'd0) ? X_START : x_rand;
          py_q[slot_q] <= y_init;
          if (slot_q == 3'd7) score_q <= '0;
        end
        RUN: begin
          if (stop) begin
            for (int i = 0; i < NUM_PLATFORMS; i++) begin
              px_q[i] <= '0;
              py_q[i] <= H;
            end
          end else if (playing && frame) begin
            dy_q <= dy_new;
            sv_q <= 1'b1;
          end
        end
        SCAN: begin
          if (respawn) begin
            py_q[slot_q] <= y_spawn;
            px_q[slot_q] <= x_rand;
            score_q      <= score_q + 16'd1;
          end else begin
            py_q[slot_q] <= y_sum;
`ifdef PLATFORM_DRIFT_EN
            px_q[slot_q] <= x_drift;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PLATFORMS; i++) begin
      bus.Platform_X[i] = px_q[i];
      bus.Platform_Y[i] = py_q[i];
    end
  end

  assign bus.platform_size = PLAT_SIZE;
  assign bus.scroll_dy     = dy_q;
  assign bus.scroll_valid  = sv_q;
  assign bus.score         = score_q;
  assign bus.busy          = (st_q == INIT) || (st_q == SCAN);

endmodule

// File: tb/tb_platform_manager.sv
// Scoreboard bench for platform_manager: random frames vs a
// slot-level reference model; monitor checks each INIT/SCAN burst.
module tb_platform_manager;
  import doodle_pkg::*;

  typedef struct packed {
    logic             frame;
    logic [9:0]       dy;
    logic [7:0][9:0]  x;
    logic [7:0][9:0]  y;
    logic [15:0]      score;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;
  always #10 Clk = ~Clk;

  platform_manager_if bus();

  platform_manager dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  bit   mon_en = 1'b1;
  logic prev_busy = 1'b0;

  int   mx[8];
  int   my[8];
  int   mscore;
  bit   mdir[8];
  logic [15:0] ml;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int rx(input logic [15:0] l);
    int off;
    off = int'(l) % 512;
    if (off >= 300) off -= 300;
    return 140 + off;
  endfunction

  always @(posedge Clk) ml <= Reset ? 16'hACE1 : lfsr_step(ml);

  task automatic check(input string n, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", n, act, req);
    end
  endtask

  task automatic check_rng(input string n, input int v, input int lo,
                           input int hi);
    total++;
    if (v < lo || v > hi) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d..%0d", n, v, lo, hi);
    end
  endtask

  function automatic exp_t snap(input bit fr, input int dy);
    exp_t e;
    e.frame = fr;
    e.dy    = 10'(dy);
    for (int i = 0; i < 8; i++) begin
      e.x[i] = 10'(mx[i]);
      e.y[i] = 10'(my[i]);
    end
    e.score = 16'(mscore);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mx[i] = 0;
      my[i] = 480;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_y%0d", tag, i), 32'(bus.Platform_Y[i]), 480);
      check($sformatf("%s_x%0d", tag, i), 32'(bus.Platform_X[i]), 0);
    end
    check({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  task automatic do_init();
    logic [15:0] l;
    l = ml;
    for (int k = 0; k < 8; k++) begin
      l = lfsr_step(l);
      my[k] = 440 - 56 * k;
      mx[k] = (k == 0) ? 290 : rx(l);
    end
    mscore = 0;
    q.push_back(snap(1'b0, 0));
    bus.state = 8'd1;
    repeat (12) @(negedge Clk);
  endtask

  task automatic do_frame(input int d, input int hold);
    logic [15:0] l;
    int dy, y;
`ifdef PLATFORM_DRIFT_EN
    int nx;
`endif
    dy = (d < 160) ? ((160 - d > 15) ? 15 : 160 - d) : 0;
    l  = ml;
    for (int i = 0; i < 8; i++) begin
      l = lfsr_step(l);
      y = my[i] + dy;
      if (y >= 480) begin
        my[i]  = (int'(l) >> 9) % 16;
        mx[i]  = rx(l);
        mscore = (mscore + 1) % 65536;
      end else begin
        my[i] = y;
`ifdef PLATFORM_DRIFT_EN
        if (i % 2 == 1) begin
          nx = mx[i] + (mdir[i] ? -1 : 1);
          if (nx < 140 || nx > 439) begin
            mdir[i] = !mdir[i];
            nx = mx[i] + (mdir[i] ? -1 : 1);
          end
          mx[i] = nx;
        end
`endif
      end
    end
    q.push_back(snap(1'b1, dy));
    bus.Doodle_Y       = 10'(d);
    bus.frame_clk_edge = 2'b01;
    repeat (hold) @(negedge Clk);
    bus.frame_clk_edge = 2'b00;
    repeat (12) @(negedge Clk);
  endtask

  task automatic check_drained(input string n);
    check(n, 32'(q.size()), 0);
    q.delete();
  endtask

  // Monitor: a busy rising edge starts an INIT or SCAN burst
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (mon_en && bus.busy && !prev_busy) begin
        if (q.size() == 0) begin
          check("unexpected_burst", 32'(bus.busy), 0);
        end else begin
          e = q.pop_front();
          if (e.frame) begin
            check("scroll_valid", 32'(bus.scroll_valid), 1);
            check("scroll_dy", 32'(bus.scroll_dy), 32'(e.dy));
          end
          for (int k = 1; k < 8; k++) begin
            @(negedge Clk);
            check($sformatf("busy_c%0d", k), 32'(bus.busy), 1);
            if (k == 1 && e.frame)
              check("scroll_valid_pulse", 32'(bus.scroll_valid), 0);
          end
          @(negedge Clk);
          check("busy_end", 32'(bus.busy), 0);
          for (int i = 0; i < 8; i++) begin
            check($sformatf("y%0d", i), 32'(bus.Platform_Y[i]),
                  32'(e.y[i]));
            check($sformatf("x%0d", i), 32'(bus.Platform_X[i]),
                  32'(e.x[i]));
            check_rng($sformatf("x%0d_range", i),
                      int'(bus.Platform_X[i]), 140, 439);
          end
          check("score", 32'(bus.score), 32'(e.score));
        end
      end
      prev_busy = bus.busy;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int d;
    Reset              = 1'b1;
    bus.state          = 8'd0;
    bus.frame_clk_edge = 2'b00;
    bus.Doodle_Y       = 10'd300;
    mscore             = 0;
    for (int i = 0; i < 8; i++) mdir[i] = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    check_idle_outputs("rst");
    check("rst_score", 32'(bus.score), 0);
    check("rst_dy", 32'(bus.scroll_dy), 0);
    check("rst_valid", 32'(bus.scroll_valid), 0);
    check("plat_size", 32'(bus.platform_size), 60);

    do_init();
    check_drained("init_drain");

    do_frame(150, 1);
    do_frame(100, 1);
    do_frame(160, 1);
    do_frame(159, 1);
    do_frame(145, 1);
    do_frame(146, 1);
    // Extra frame edges inside SCAN must be ignored
    do_frame(120, 3);
    check_drained("fixed_drain");

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) d = $urandom_range(161, 479);
      else d = $urandom_range(90, 165);
      do_frame(d, 1);
    end
    check_drained("rand_drain");

    // Frozen game state: frame edge must not scroll
    bus.state          = 8'd5;
    bus.Doodle_Y       = 10'd50;
    bus.frame_clk_edge = 2'b01;
    @(negedge Clk);
    bus.frame_clk_edge = 2'b00;
    repeat (12) @(negedge Clk);
    for (int i = 0; i < 8; i++)
      check($sformatf("frz_y%0d", i), 32'(bus.Platform_Y[i]), 32'(my[i]));
    check("frz_score", 32'(bus.score), 32'(mscore));
    bus.state = 8'd1;
    @(negedge Clk);

    // Back to menu clears the field
    bus.state = 8'd0;
    repeat (2) @(negedge Clk);
    model_reset();
    check_idle_outputs("menu");
    check("menu_score", 32'(bus.score), 32'(mscore));

    do_init();
    do_frame(100, 1);
    check_drained("reinit_drain");

    // Reset while SCAN is on slot 3
    mon_en = 1'b0;
    bus.Doodle_Y       = 10'd100;
    bus.frame_clk_edge = 2'b01;
    @(negedge Clk);
    bus.frame_clk_edge = 2'b00;
    repeat (3) @(negedge Clk);
    Reset     = 1'b1;
    bus.state = 8'd0;
    @(negedge Clk);
    check_idle_outputs("mid");
    check("mid_score", 32'(bus.score), 0);
    check("mid_dy", 32'(bus.scroll_dy), 0);
    Reset = 1'b0;
    repeat (10) @(negedge Clk);
    check_idle_outputs("post");
    mscore = 0;
    for (int i = 0; i < 8; i++) mdir[i] = 1'b0;
    model_reset();
    mon_en = 1'b1;

    do_init();
    for (int n = 0; n < 4; n++) do_frame($urandom_range(95, 170), 1);
    check_drained("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
